instr_mem_loader: RTL
=====================

# instr_mem_loader

Program loader that drives the write port of the 1024×32 instruction memory from a byte stream (host/UART side). On a start command it holds the CPU in stall, assembles little-endian bytes into 32-bit instruction words, and issues one memory write per word at incrementing addresses. A trailing XOR checksum byte is compared against the received data, and the result is reported with a done pulse. It sits between the host byte receiver and the instruction memory's `i_Write_Addr`/`i_Write_Instr`/`i_MemWrite` inputs.

## Interface
Parameters:
- `P_ADDR_W`, 10: instruction memory address width (1024 words).
- `P_BASE_ADDR`, 0: first word address written by every load.

Ports:
- `i_CLK` in 1: single clock; all logic on posedge.
- `i_RST` in 1: synchronous, active-high reset.
- `i_Load_Start` in 1: one-cycle start request, sampled only in IDLE.
- `i_Load_Len` in `P_ADDR_W+1`: word count, sampled with start; legal range 1..2^`P_ADDR_W`.
- `i_Byte` in 8: stream data byte.
- `i_Byte_Valid` in 1: `i_Byte` valid this cycle.
- `o_Byte_Ready` out 1: loader accepts a byte this cycle; transfer occurs when valid & ready at posedge.
- `o_Write_Addr` out `P_ADDR_W`: memory write address.
- `o_Write_Instr` out 32: memory write data.
- `o_MemWrite` out 1: memory write strobe, one cycle per word.
- `o_CPU_Stall` out 1: high while a load is in progress.
- `o_Done` out 1: one-cycle pulse at end of load.
- `o_Error` out 1: checksum mismatch flag, held until the next accepted start or reset.

## Operation
- States: IDLE, RECV, WRITE, CHECK, DONE.
- IDLE: ready=0, stall=0. Start with len in 1..2^`P_ADDR_W` latches len, clears the word counter, byte index, and running XOR, loads the address register with `P_BASE_ADDR`, clears `o_Error`, and moves to RECV. Start with len=0 or len>2^`P_ADDR_W` is ignored.
- RECV: ready=1. Each accepted byte is XORed into the checksum and placed in lane [8k+7:8k], where k = byte index 0..3; the first byte is the LSB. Acceptance of the 4th byte moves the state to WRITE.
- WRITE: ready=0, `o_MemWrite`=1, `o_Write_Addr`=current address, `o_Write_Instr`=assembled word. Afterwards the address increments modulo 2^`P_ADDR_W` (wrap-around permitted) and the word counter increments. If the counter reaches len, the next state is CHECK; otherwise RECV.
- CHECK: ready=1. The accepted byte is the checksum. `o_Error` is set to 1 if the byte differs from the running XOR of all data bytes; otherwise it is 0. The next state is DONE.
- DONE: `o_Done`=1 for exactly one cycle, stall still 1. The next state is IDLE.
- `o_Write_Addr`/`o_Write_Instr` hold their last values when `o_MemWrite`=0.
- `i_Load_Start` outside IDLE is ignored; a load cannot be aborted except by reset.
- `i_Byte` is ignored whenever `o_Byte_Ready`=0 or `i_Byte_Valid`=0. Stalls on the byte side of any length are tolerated with no timeout.

## Timing
- Reset (synchronous): state=IDLE. All outputs are 0: ready, MemWrite, stall, Done, Error, Write_Addr, and Write_Instr.
- Reset mid-load returns to IDLE in the next cycle with stall=0. Words already written remain in memory, and no Done is produced.
- Start is accepted at edge T. From T+1: state RECV, stall=1, ready=1.
- The 4th byte of a word is accepted at edge N. In cycle N+1, `o_MemWrite`=1 and ready=0. In cycle N+2, ready=1 again (RECV or CHECK).
- Peak throughput is 4 bytes per 5 cycles; minimum load time is 5·len+2 cycles after start.
- The checksum byte is accepted at edge C. In cycle C+1: `o_Done`=1 with `o_Error` already valid. In cycle C+2: stall=0, state IDLE, and a new start can be accepted.
- `o_Error` stays stable after Done until the next accepted start, which clears it, or until reset.

## Test plan
- Load of 2 words with bytes 78 56 34 12 EF BE AD DE and checksum 2A, all valid back-to-back: writes 0x12345678@0 then 0xDEADBEEF@1, Done pulse, Error=0. Stall rises the cycle after start and falls the cycle after Done.
- Same stream with checksum 2B: identical writes, Done with Error=1. A new start (len=1) clears Error.
- `P_BASE_ADDR`=1023, len=2: writes land at 1023 then 0 (wrap). `i_Byte_Valid` toggling with random gaps leaves the written data unchanged.
- Start with len=0 or len=1025: remains IDLE, stall=0, no writes. Start pulsed during RECV: ignored, and the current load completes normally.
- Reset asserted after 5 data bytes of a 3-word load: next cycle all outputs are 0 and state is IDLE. Word 0 is written, word 1 is not, and Done never pulses.
- Full 1024-word load, `P_BASE_ADDR`=0: exactly 1024 MemWrite pulses at addresses 0..1023 and a correct checksum with Error=0. Read-back through the memory read port matches the stream.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader_if
// Purpose  : Bundles the host byte stream, load command and instruction
//            memory write port of the program loader.
// Ports    : i_Load_Start/i_Load_Len  - load command and word count
//            i_Byte/i_Byte_Valid      - host byte stream
//            o_Byte_Ready             - loader accepts a byte
//            o_Write_Addr/o_Write_Instr/o_MemWrite - memory write port
//            o_CPU_Stall/o_Done/o_Error - load status
//            Modport slave: the loader. Modport master: host/memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if #(
  parameter int P_ADDR_W = 10
);
  logic                i_Load_Start;
  logic [P_ADDR_W:0]   i_Load_Len;
  logic [7:0]          i_Byte;
  logic                i_Byte_Valid;
  logic                o_Byte_Ready;
  logic [P_ADDR_W-1:0] o_Write_Addr;
  logic [31:0]         o_Write_Instr;
  logic                o_MemWrite;
  logic                o_CPU_Stall;
  logic                o_Done;
  logic                o_Error;

  modport slave (
    input  i_Load_Start, i_Load_Len, i_Byte, i_Byte_Valid,
    output o_Byte_Ready, o_Write_Addr, o_Write_Instr, o_MemWrite,
           o_CPU_Stall, o_Done, o_Error
  );

  modport master (
    output i_Load_Start, i_Load_Len, i_Byte, i_Byte_Valid,
    input  o_Byte_Ready, o_Write_Addr, o_Write_Instr, o_MemWrite,
           o_CPU_Stall, o_Done, o_Error
  );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Loads the instruction memory from a little-endian byte stream.
//            A start command stalls the CPU, each group of four bytes becomes
//            one memory write at an incrementing address, and a trailing XOR
//            checksum byte is verified before a one-cycle done pulse.
// Ports    : i_CLK  - clock, all logic on the rising edge
//            i_RST  - synchronous active-high reset
//            bus    - instr_mem_loader_if.slave (command, byte stream,
//                     memory write port and status)
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
  parameter int          P_ADDR_W    = 10,
  parameter int unsigned P_BASE_ADDR = 0
) (
  input  wire logic          i_CLK,
  input  wire logic          i_RST,
  instr_mem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [P_ADDR_W-1:0] C_BASE    = P_BASE_ADDR[P_ADDR_W-1:0];
  // 2^P_ADDR_W: largest legal word count
  localparam logic [P_ADDR_W:0]   C_MAX_LEN = {1'b1, {P_ADDR_W{1'b0}}};

  state_t              r_state;
  state_t              w_state_next;

  logic [P_ADDR_W:0]   r_len;
  logic [P_ADDR_W:0]   r_cnt;
  logic [1:0]          r_idx;
  logic [7:0]          r_xor;
  logic [P_ADDR_W-1:0] r_addr;
  logic [31:0]         r_word;
  logic [P_ADDR_W-1:0] r_wr_addr;
  logic [31:0]         r_wr_instr;
  logic                r_err;

  logic                w_ready;
  logic                w_memwrite;
  logic                w_stall;
  logic                w_done;
  logic                w_len_ok;
  logic                w_start_ok;
  logic                w_fire;
  logic                w_last_word;

  assign w_len_ok    = (bus.i_Load_Len != '0) && (bus.i_Load_Len <= C_MAX_LEN);
  assign w_start_ok  = (r_state == S_IDLE) && bus.i_Load_Start && w_len_ok;
  assign w_fire      = w_ready && bus.i_Byte_Valid;
  assign w_last_word = ((r_cnt + (P_ADDR_W+1)'(1)) == r_len);

  // State register
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_memwrite   = 1'b0;
    w_stall      = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = 1'b0;
        if (w_start_ok) begin
          w_state_next = S_RECV;
        end
      end
      S_RECV: begin
        w_ready = 1'b1;
        if (bus.i_Byte_Valid && (r_idx == 2'd3)) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_memwrite   = 1'b1;
        w_state_next = w_last_word ? S_CHECK : S_RECV;
      end
      S_CHECK: begin
        w_ready = 1'b1;
        if (bus.i_Byte_Valid) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_stall      = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: word assembly, checksum, address and word counters
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_len      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_xor      <= '0;
      r_addr     <= '0;
      r_word     <= '0;
      r_wr_addr  <= '0;
      r_wr_instr <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_len  <= bus.i_Load_Len;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_xor  <= '0;
            r_addr <= C_BASE;
            r_err  <= 1'b0;
          end
        end
        S_RECV: begin
          if (w_fire) begin
            r_xor              <= r_xor ^ bus.i_Byte;
            r_idx              <= r_idx + 2'd1;
            r_word[8*r_idx +: 8] <= bus.i_Byte;
            // Capture the write port on the final byte so the word and its
            // address are presented during WRITE and then held afterwards.
            if (r_idx == 2'd3) begin
              r_wr_addr  <= r_addr;
              r_wr_instr <= {bus.i_Byte, r_word[23:0]};
            end
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + P_ADDR_W'(1);
          r_cnt  <= r_cnt + (P_ADDR_W+1)'(1);
        end
        S_CHECK: begin
          if (w_fire) begin
            r_err <= (bus.i_Byte != r_xor);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_Byte_Ready  = w_ready;
  assign bus.o_MemWrite    = w_memwrite;
  assign bus.o_CPU_Stall   = w_stall;
  assign bus.o_Done        = w_done;
  assign bus.o_Error       = r_err;
  assign bus.o_Write_Addr  = r_wr_addr;
  assign bus.o_Write_Instr = r_wr_instr;

endmodule
`default_nettype wire
